// File: rtl/stream_arbiter_qos_rr.sv
// stream_arbiter_qos_rr: packet-level QoS/round-robin stream arbiter with starvation aging and a registered output slot
module stream_arbiter_qos_rr #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 4,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
  input  logic [STREAM_COUNT-1:0]                    s_last_i,
  input  logic [STREAM_COUNT-1:0]                    s_valid_i,
  output logic [STREAM_COUNT-1:0]                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                    m_data_o,
  output logic [T_QOS__WIDTH-1:0]                    m_qos_o,
  output logic [T_ID___WIDTH-1:0]                    m_id_o,
  output logic                                       m_last_o,
  output logic                                       m_valid_o,
  input  logic                                       m_ready_i
);
  localparam int CW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t                  state_q;
  logic [T_ID___WIDTH-1:0] grant_q, rr_q, win, sel, idx;
  logic [CW-1:0]           starve_q [STREAM_COUNT];
  logic [STREAM_COUNT-1:0] starved, top, cand;
  logic [T_QOS__WIDTH-1:0] max_qos;
  logic [T_DATA_WIDTH-1:0] m_data_q;
  logic [T_QOS__WIDTH-1:0] m_qos_q;
  logic [T_ID___WIDTH-1:0] m_id_q;
  logic                    m_last_q, m_valid_q, slot_free, accept;
  always_comb begin
    max_qos = '0;
    for (int i = 0; i < STREAM_COUNT; i++)
      max_qos = (s_valid_i[i] && s_qos_i[i] > max_qos) ? s_qos_i[i] : max_qos;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      starved[i] = (STARVE_LIMIT != 0) && s_valid_i[i] && starve_q[i] == LIM;
      top[i]     = s_valid_i[i] && s_qos_i[i] == max_qos;
    end
    cand = |starved ? starved : top;
    win  = '0;
    idx  = '0;
    for (int k = STREAM_COUNT; k >= 1; k--) begin
      idx = T_ID___WIDTH'((int'(rr_q) + k) % STREAM_COUNT);
      win = cand[idx] ? idx : win;
    end
  end
  assign slot_free = ~m_valid_q | m_ready_i;
  assign sel       = (state_q == LOCKED) ? grant_q : win;
  assign s_ready_o = (rst_i || !slot_free || (state_q == IDLE && !(|cand))) ? '0 : STREAM_COUNT'(1) << sel;
  assign accept    = |(s_ready_o & s_valid_i);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= T_ID___WIDTH'(STREAM_COUNT - 1);
      m_data_q  <= '0;
      m_qos_q   <= '0;
      m_id_q    <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      for (int i = 0; i < STREAM_COUNT; i++) starve_q[i] <= '0;
    end else begin
      if (accept) begin
        m_data_q  <= s_data_i[sel];
        m_qos_q   <= s_qos_i[sel];
        m_id_q    <= sel;
        m_last_q  <= s_last_i[sel];
        m_valid_q <= 1'b1;
      end else if (m_ready_i) m_valid_q <= 1'b0;
      if (accept && state_q == IDLE) begin
        rr_q <= win;
        if (!s_last_i[sel]) begin
          state_q <= LOCKED;
          grant_q <= win;
        end
        for (int i = 0; i < STREAM_COUNT; i++)
          starve_q[i] <= (T_ID___WIDTH'(i) == win) ? '0 :
                         (s_valid_i[i] && starve_q[i] != LIM) ? starve_q[i] + CW'(1) : starve_q[i];
      end else if (accept && s_last_i[sel]) state_q <= IDLE;
    end
  end
  assign m_data_o  = m_data_q;
  assign m_qos_o   = m_qos_q;
  assign m_id_o    = m_id_q;
  assign m_last_o  = m_last_q;
  assign m_valid_o = m_valid_q;
endmodule

// File: tb/tb_stream_arbiter_qos_rr.sv
// tb_stream_arbiter_qos_rr: directed self-checking bench for stream_arbiter_qos_rr
module tb_stream_arbiter_qos_rr;
  logic            clk = 1'b0, rst = 1'b1, m_ready = 1'b1;
  logic [3:0][7:0] s_data = '0;
  logic [3:0][3:0] s_qos = '0;
  logic [3:0]      s_last = '0, s_valid = '0, s_ready;
  logic [7:0]      m_data;
  logic [3:0]      m_qos;
  logic [1:0]      m_id;
  logic            m_last, m_valid;
  logic            b [4];
  int              checks = 0, errors = 0, eid, eb;
  stream_arbiter_qos_rr dut (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_qos_i(s_qos), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .m_data_o(m_data), .m_qos_o(m_qos),
    .m_id_o(m_id), .m_last_o(m_last), .m_valid_o(m_valid), .m_ready_i(m_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    s_qos   = '0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    clr();
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    s_valid = 4'hF;
    tick();
    #1;
    chk("rst_ready", s_ready, 0);
    tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_id", m_id, 0);
    chk("rst_last", m_last, 0);
    do_reset();
    s_valid = 4'b0100; s_data[2] = 8'h11;
    #1 chk("t1_rdy0", s_ready, 4'b0100);
    tick();
    chk("t1_v0", m_valid, 1); chk("t1_d0", m_data, 8'h11); chk("t1_id0", m_id, 2); chk("t1_l0", m_last, 0);
    s_data[2] = 8'h22;
    #1 chk("t1_rdy1", s_ready, 4'b0100);
    tick();
    chk("t1_d1", m_data, 8'h22); chk("t1_l1", m_last, 0);
    s_data[2] = 8'h33; s_last[2] = 1'b1;
    tick();
    chk("t1_d2", m_data, 8'h33); chk("t1_id2", m_id, 2); chk("t1_l2", m_last, 1);
    clr();
    tick();
    chk("t1_drain", m_valid, 0);
    s_valid = 4'b1011; s_qos[0] = 4'd2; s_qos[1] = 4'd7; s_qos[3] = 4'd5; s_last = 4'b1011;
    s_data[0] = 8'hA0; s_data[1] = 8'hA1; s_data[3] = 8'hA3;
    #1 chk("t2_rdy_a", s_ready, 4'b0010);
    tick();
    chk("t2_id_a", m_id, 1); chk("t2_d_a", m_data, 8'hA1); chk("t2_q_a", m_qos, 7);
    s_valid[1] = 1'b0;
    #1 chk("t2_rdy_b", s_ready, 4'b1000);
    tick();
    chk("t2_id_b", m_id, 3); chk("t2_q_b", m_qos, 5);
    s_valid[3] = 1'b0;
    #1 chk("t2_rdy_c", s_ready, 4'b0001);
    tick();
    chk("t2_id_c", m_id, 0); chk("t2_d_c", m_data, 8'hA0);
    clr();
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) b[i] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      eid = (c / 2) % 4;
      eb  = c % 2;
      for (int i = 0; i < 4; i++) begin
        s_valid[i] = 1'b1;
        s_qos[i]   = 4'd3;
        s_data[i]  = 8'(i * 16 + int'(b[i]));
        s_last[i]  = b[i];
      end
      #1 chk("t3_rdy", s_ready, 4'b1 << eid);
      tick();
      chk("t3_id", m_id, eid); chk("t3_data", m_data, eid * 16 + eb); chk("t3_last", m_last, eb);
      b[eid] = ~b[eid];
    end
    clr();
    tick();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      eid = (c == 4) ? 1 : 0;
      s_valid = {2'b00, c <= 4, 1'b1};
      s_qos[0] = 4'd9; s_qos[1] = 4'd1; s_last = 4'b0011;
      s_data[0] = 8'(8'h90 + c); s_data[1] = 8'h51;
      #1 chk("t4_rdy", s_ready, 4'b1 << eid);
      tick();
      chk("t4_id", m_id, eid);
    end
    clr();
    tick();
    s_valid = 4'b1000; s_qos[3] = 4'd2; s_data[3] = 8'hD0;
    tick();
    chk("t5_d0", m_data, 8'hD0);
    s_data[3] = 8'hD1;
    tick();
    chk("t5_d1", m_data, 8'hD1);
    s_data[3] = 8'hD2; m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("t5_stall_rdy", s_ready, 0);
      tick();
      chk("t5_stall_d", m_data, 8'hD1); chk("t5_stall_v", m_valid, 1);
    end
    m_ready = 1'b1;
    #1 chk("t5_rel_rdy", s_ready, 4'b1000);
    tick();
    chk("t5_d2", m_data, 8'hD2); chk("t5_l2", m_last, 0);
    s_data[3] = 8'hD3; s_last[3] = 1'b1;
    tick();
    chk("t5_d3", m_data, 8'hD3); chk("t5_l3", m_last, 1);
    clr();
    tick();
    chk("t5_drain", m_valid, 0);
    s_valid = 4'b0100; s_data[2] = 8'hE0;
    #1 chk("t6_rdy0", s_ready, 4'b0100);
    tick();
    chk("t6_d0", m_data, 8'hE0);
    s_data[2] = 8'hE1; rst = 1'b1;
    #1 chk("t6_rst_rdy", s_ready, 0);
    tick();
    chk("t6_rst_v", m_valid, 0);
    rst = 1'b0;
    s_valid = 4'b0101; s_last = 4'b0101; s_data[0] = 8'hF0; s_data[2] = 8'hF2;
    #1 chk("t6_rearb_rdy", s_ready, 4'b0001);
    tick();
    chk("t6_rearb_id", m_id, 0); chk("t6_rearb_d", m_data, 8'hF0);
    clr();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
